// File: rtl/synth_pkg.sv
// Shared constants, sample/phase types and the sequencer note table for the tone synthesiser.
package synth_pkg;

  localparam int FS_DIV   = 2048;
  localparam int SCK_DIV  = 32;
  localparam int MCLK_DIV = 8;
  localparam int SAMPLE_W = 24;
  localparam int PHASE_W  = 24;
  localparam int DIV_W    = $clog2(FS_DIV);
  localparam int SLOT_W   = $clog2(FS_DIV / (2 * SCK_DIV));

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [PHASE_W-1:0]         phase_t;

  // Per-frame phase step for C4..D6, f * 2^24 / 48828.125 rounded; A4 uses the reference value 151182.
  function automatic phase_t note_inc(input logic [3:0] n);
    case (n)
      4'd0:    return 24'd89894;
      4'd1:    return 24'd100902;
      4'd2:    return 24'd113259;
      4'd3:    return 24'd119994;
      4'd4:    return 24'd134689;
      4'd5:    return 24'd151182;
      4'd6:    return 24'd169697;
      4'd7:    return 24'd179788;
      4'd8:    return 24'd201805;
      4'd9:    return 24'd226518;
      4'd10:   return 24'd239988;
      4'd11:   return 24'd269377;
      4'd12:   return 24'd302366;
      4'd13:   return 24'd339394;
      4'd14:   return 24'd359575;
      default: return 24'd403610;
    endcase
  endfunction

endpackage

// File: rtl/synth_top_i2s_tx.sv
// I2S transmitter: owns the clock divider, emits MCLK/SCK/LRCK and shifts each sample out MSB first.
module i2s_tx
  import synth_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t sample,
  output logic    mclk,
  output logic    sck,
  output logic    lrck,
  output logic    sdout,
  output logic    frame_strobe
);

  localparam int MCLK_BIT = $clog2(MCLK_DIV) - 1;
  localparam int SCK_BIT  = $clog2(SCK_DIV) - 1;
  localparam int SLOT_LSB = $clog2(SCK_DIV);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              mclk_q, mclk_d;
  logic              sck_q, sck_d;
  logic              lrck_q, lrck_d;
  logic              sdout_q, sdout_d;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] bit_idx;

  always_comb begin
    div_d   = div_q + DIV_W'(1);
    slot    = div_d[SLOT_LSB +: SLOT_W];
    bit_idx = SLOT_W'(SAMPLE_W) - slot;
    mclk_d  = div_d[MCLK_BIT];
    sck_d   = div_d[SCK_BIT];
    lrck_d  = div_d[DIV_W-1];
    sdout_d = sdout_q;
    // Data changes with SCK falling; slot 0 is the one-bit I2S delay after LRCK.
    if (&div_q[SCK_BIT:0]) begin
      sdout_d = 1'b0;
      if (slot != '0 && slot <= SLOT_W'(SAMPLE_W))
        sdout_d = sample[bit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      mclk_q  <= 1'b0;
      sck_q   <= 1'b0;
      lrck_q  <= 1'b0;
      sdout_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      mclk_q  <= mclk_d;
      sck_q   <= sck_d;
      lrck_q  <= lrck_d;
      sdout_q <= sdout_d;
    end
  end

  assign frame_strobe = &div_q;
  assign mclk         = mclk_q;
  assign sck          = sck_q;
  assign lrck         = lrck_q;
  assign sdout        = sdout_q;

endmodule

// File: rtl/synth_top.sv
// Tone synthesiser top: 16-note sequencer, 24-bit phase accumulator and waveform feeding an I2S DAC.
// Define SAW_WAVE_EN to generate a sawtooth instead of the default square wave.
module synth_top
  import synth_pkg::*;
#(
  parameter int                  STEP_SAMPLES = 12207,
  parameter logic [SAMPLE_W-1:0] AMP          = 24'h100000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] led,
  output logic       mclk,
  output logic       lrck,
  output logic       sck,
  output logic       sdout,
  output logic [3:0] pos
);

  localparam int               CNT_W    = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_SAMPLES - 1);

  function automatic sample_t wave(input phase_t ph);
`ifdef SAW_WAVE_EN
    sample_t centred;
    centred = sample_t'(ph - 24'h800000);
    return centred >>> 3;
`else
    return ph[PHASE_W-1] ? sample_t'(-AMP) : sample_t'(AMP);
`endif
  endfunction

  phase_t           phase_q, phase_d;
  sample_t          sample_q, sample_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [3:0]       pos_q, pos_d;
  logic             frame_strobe;

  // Phase keeps running across note changes so the waveform stays continuous.
  always_comb begin
    phase_d    = phase_q;
    sample_d   = sample_q;
    step_cnt_d = step_cnt_q;
    pos_d      = pos_q;
    if (frame_strobe) begin
      phase_d  = phase_q + note_inc(pos_q);
      sample_d = wave(phase_d);
      if (step_cnt_q == CNT_LAST) begin
        step_cnt_d = '0;
        pos_d      = pos_q + 4'd1;
      end else begin
        step_cnt_d = step_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      sample_q   <= '0;
      step_cnt_q <= '0;
      pos_q      <= '0;
    end else begin
      phase_q    <= phase_d;
      sample_q   <= sample_d;
      step_cnt_q <= step_cnt_d;
      pos_q      <= pos_d;
    end
  end

  i2s_tx u_i2s_tx (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample_q),
    .mclk         (mclk),
    .sck          (sck),
    .lrck         (lrck),
    .sdout        (sdout),
    .frame_strobe (frame_strobe)
  );

  assign led = {sample_q[SAMPLE_W-1 -: 4], pos_q};
  assign pos = pos_q;

endmodule

// File: tb/tb_synth_top.sv
// Randomised-reset bench for synth_top: a frame-level arithmetic model predicts every output each cycle.
`timescale 1ns/1ps
module tb_synth_top;

  localparam int          STEP   = 2;
  localparam logic [23:0] AMP_TB = 24'hA5F00F;   // full-width pattern, also shows the MSB slot
  localparam int          NFR    = 40;
  localparam logic [23:0] INC_TAB [16] = '{
    24'd89894,  24'd100902, 24'd113259, 24'd119994,
    24'd134689, 24'd151182, 24'd169697, 24'd179788,
    24'd201805, 24'd226518, 24'd239988, 24'd269377,
    24'd302366, 24'd339394, 24'd359575, 24'd403610};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] led;
  logic       mclk, lrck, sck, sdout;
  logic [3:0] pos;

  int   total = 0;
  int   bad   = 0;
  int   t     = 0;
  bit   chk_en = 1'b0;
  logic [23:0] phase_at [NFR+1];

  synth_top #(.STEP_SAMPLES(STEP), .AMP(AMP_TB)) dut (
    .clk   (clk),
    .rst   (rst),
    .led   (led),
    .mclk  (mclk),
    .lrck  (lrck),
    .sck   (sck),
    .sdout (sdout),
    .pos   (pos)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic logic [23:0] wave_m(input logic [23:0] ph);
`ifdef SAW_WAVE_EN
    int v;
    v = int'(ph) - 8388608;
    return 24'(v >>> 3);
`else
    return (ph >= 24'h800000) ? 24'(25'h1000000 - 25'(AMP_TB)) : AMP_TB;
`endif
  endfunction

  task automatic wait_until(input int target);
    int n = 0;
    while (t < target && n < 100000) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_budget", 32'(t >= target), 32'd1);
  endtask

  // Continuous compare against the frame-level model.
  initial begin : cmp
    int          dv, f, k;
    logic [23:0] s;
    logic [3:0]  pe;
    logic [4:0]  bi;
    logic        eb, prev_lrck;
    logic [15:0] exp_o, act_o;
    prev_lrck = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        dv = t % 2048;
        f  = t / 2048;
        if (f <= NFR) begin
          k  = (dv % 1024) / 32;
          s  = (f == 0) ? 24'h0 : wave_m(phase_at[f]);
          pe = 4'((f / STEP) % 16);
          bi = 5'(24 - k);
          eb = (k >= 1 && k <= 24) ? s[bi] : 1'b0;
          exp_o = {s[23:20], pe, pe, 1'(dv >> 2), 1'(dv >> 4), 1'(dv >> 10), eb};
          act_o = {led, pos, mclk, sck, lrck, sdout};
          check("outputs", 32'(act_o), 32'(exp_o));
          check("phase", 32'(dut.phase_q), 32'(phase_at[f]));
        end
        if (lrck !== prev_lrck) check("lrck_while_sck_low", 32'(sck), 32'd0);
        prev_lrck = lrck;
      end
    end
  end

  initial begin : stim
    int          n, cm, cs, cl;
    logic        pm, ps, pl;
    logic [63:0] word;

    phase_at[0] = 24'h0;
    for (int j = 1; j <= NFR; j++)
      phase_at[j] = phase_at[j-1] + INC_TAB[((j - 1) / STEP) % 16];
    check("model_c4_twice", 32'(phase_at[2]), 32'd179788);
    check("model_a4_step", 32'(phase_at[12] - phase_at[10]), 32'd302364);

    // Reset held for a random 2..4 cycles.
    repeat ($urandom_range(4, 2)) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_outputs", 32'({led, pos, mclk, lrck, sck, sdout}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    n = 0;
    while (mclk !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check("mclk_first_high", 32'(n), 32'd4);
    while (lrck !== 1'b1 && n < 1100) begin @(posedge clk); #1; n++; end
    check("lrck_first_rise", 32'(n), 32'd1024);

    cm = 0; cs = 0; cl = 0;
    pm = mclk; ps = sck; pl = lrck;
    repeat (4096) begin
      @(posedge clk); #1;
      if (mclk && !pm) cm++;
      if (sck && !ps)  cs++;
      if (lrck && !pl) cl++;
      pm = mclk; ps = sck; pl = lrck;
    end
    check("mclk_periods", 32'(cm), 32'd512);
    check("sck_periods", 32'(cs), 32'd128);
    check("lrck_periods", 32'(cl), 32'd2);

    // One full stereo frame sampled at slot centres.
    wait_until(3 * 2048 + 16);
    word = '0;
    for (int i = 0; i < 64; i++) begin
      word[63 - i] = sdout;
      repeat (32) @(posedge clk);
      #1;
    end
`ifndef SAW_WAVE_EN
    check("serial_left", 32'(word[63:32]), 32'h52F80780);
    check("serial_right", 32'(word[31:0]), 32'h52F80780);
`endif
    check("serial_left_eq_right", 32'(word[63:32]), 32'(word[31:0]));

    wait_until(31 * 2048 + 5);
    check("pos_15", 32'(pos), 32'd15);
    check("led_tracks_pos", 32'(led[3:0]), 32'd15);
    wait_until(32 * 2048 + 5);
    check("pos_wrap", 32'(pos), 32'd0);

    wait_until(35 * 2048 + 1500);
    check("pre_reset_lrck", 32'(lrck), 32'd1);
    check("pre_reset_pos", 32'(pos), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_clocks", 32'({lrck, sck, mclk, sdout}), 32'd0);
    check("midrst_pos", 32'(pos), 32'd0);
    check("midrst_phase", 32'(dut.phase_q), 32'd0);
    rst = 1'b0;
    wait_until(1023);
    check("resume_lrck_low", 32'(lrck), 32'd0);
    wait_until(1024);
    check("resume_lrck_high", 32'(lrck), 32'd1);
    wait_until(2048 + 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
